// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble stall,
// branch/jump squash, global freeze and flush deferral across a freeze.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [2:0]      id_aluop,
  input  logic [1:0]      id_memtoreg,
  input  logic [1:0]      id_pcsrc,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic            id_lw,
  input  logic            id_sw,
  input  logic            id_beq,
  input  logic            id_bge,
  input  logic            id_lui,
  input  logic            id_jal,
  input  logic            id_jalr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  output logic            ex_valid,
  output logic [2:0]      ex_aluop,
  output logic [1:0]      ex_memtoreg,
  output logic [1:0]      ex_pcsrc,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_lw,
  output logic            ex_sw,
  output logic            ex_beq,
  output logic            ex_bge,
  output logic            ex_lui,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            stall_if,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [2:0]      aluop;
    logic [1:0]      memtoreg;
    logic [1:0]      pcsrc;
    logic            alusrc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            lw;
    logic            sw;
    logic            beq;
    logic            bge;
    logic            lui;
    logic            jal;
    logic            jalr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } bundle_t;

  bundle_t         id_b;
  bundle_t         ex_q, ex_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            fpend_q, fpend_d;
  logic            uses_rs1, uses_rs2, load_use, eff_flush;

  assign id_b = '{valid: id_valid, aluop: id_aluop, memtoreg: id_memtoreg,
                  pcsrc: id_pcsrc, alusrc: id_alusrc, regwrite: id_regwrite,
                  memread: id_memread, memwrite: id_memwrite, branch: id_branch,
                  lw: id_lw, sw: id_sw, beq: id_beq, bge: id_bge, lui: id_lui,
                  jal: id_jal, jalr: id_jalr, pc: id_pc, rs1_data: id_rs1_data,
                  rs2_data: id_rs2_data, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
                  rd: id_rd};

  // Hazard detection against the load currently sitting in EX
  always_comb begin
    uses_rs1  = ~(id_lui | id_jal);
    uses_rs2  = ~id_alusrc | id_sw | id_branch;
    load_use  = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
                ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));
    eff_flush = flush | fpend_q;
    stall_if  = load_use & ~eff_flush & ~hold;
  end

  // Next-state selection: freeze > flush > load-use bubble > pass-through
  always_comb begin
    ex_d    = ex_q;
    cnt_d   = cnt_q;
    fpend_d = fpend_q;
    if (hold) begin
      fpend_d = fpend_q | flush;
    end else if (eff_flush) begin
      ex_d    = '0;
      fpend_d = 1'b0;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end else begin
      ex_d = id_b;
    end
  end

  // State registers; reset overrides freeze and any pending flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_aluop    = ex_q.aluop;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_pcsrc    = ex_q.pcsrc;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_branch   = ex_q.branch;
  assign ex_lw       = ex_q.lw;
  assign ex_sw       = ex_q.sw;
  assign ex_beq      = ex_q.beq;
  assign ex_bge      = ex_q.bge;
  assign ex_lui      = ex_q.lui;
  assign ex_jal      = ex_q.jal;
  assign ex_jalr     = ex_q.jalr;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios plus random traffic
// against a cycle-level reference model of the EX slot.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNTW   = 4;
  localparam int          CNTMAX = (1 << CNTW) - 1;

  typedef struct packed {
    logic            valid;
    logic [2:0]      aluop;
    logic [1:0]      memtoreg;
    logic [1:0]      pcsrc;
    logic            alusrc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            lw;
    logic            sw;
    logic            beq;
    logic            bge;
    logic            lui;
    logic            jal;
    logic            jalr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } instr_t;

  typedef struct packed {
    logic            stall;
    instr_t          ex;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, hold, flush;
  instr_t id_i, act;
  logic            ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite;
  logic            ex_branch, ex_lw, ex_sw, ex_beq, ex_bge, ex_lui, ex_jal, ex_jalr;
  logic [2:0]      ex_aluop;
  logic [1:0]      ex_memtoreg, ex_pcsrc;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            stall_if;
  logic [CNTW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Reference model state
  instr_t m_ex;
  int     m_cnt;
  bit     m_fpend;
  bit     m_known = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_i.valid), .id_aluop(id_i.aluop), .id_memtoreg(id_i.memtoreg),
    .id_pcsrc(id_i.pcsrc), .id_alusrc(id_i.alusrc), .id_regwrite(id_i.regwrite),
    .id_memread(id_i.memread), .id_memwrite(id_i.memwrite), .id_branch(id_i.branch),
    .id_lw(id_i.lw), .id_sw(id_i.sw), .id_beq(id_i.beq), .id_bge(id_i.bge),
    .id_lui(id_i.lui), .id_jal(id_i.jal), .id_jalr(id_i.jalr), .id_pc(id_i.pc),
    .id_rs1_data(id_i.rs1_data), .id_rs2_data(id_i.rs2_data), .id_imm(id_i.imm),
    .id_rs1(id_i.rs1), .id_rs2(id_i.rs2), .id_rd(id_i.rd),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_memtoreg(ex_memtoreg),
    .ex_pcsrc(ex_pcsrc), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_lw(ex_lw), .ex_sw(ex_sw), .ex_beq(ex_beq), .ex_bge(ex_bge),
    .ex_lui(ex_lui), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .stall_if(stall_if), .stall_cnt(stall_cnt)
  );

  assign act = '{valid: ex_valid, aluop: ex_aluop, memtoreg: ex_memtoreg,
                 pcsrc: ex_pcsrc, alusrc: ex_alusrc, regwrite: ex_regwrite,
                 memread: ex_memread, memwrite: ex_memwrite, branch: ex_branch,
                 lw: ex_lw, sw: ex_sw, beq: ex_beq, bge: ex_bge, lui: ex_lui,
                 jal: ex_jal, jalr: ex_jalr, pc: ex_pc, rs1_data: ex_rs1_data,
                 rs2_data: ex_rs2_data, imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2,
                 rd: ex_rd};

  // Instruction builders
  function automatic instr_t base();
    instr_t i;
    i = '0;
    i.valid = 1'b1;
    i.pc = $urandom; i.rs1_data = $urandom; i.rs2_data = $urandom; i.imm = $urandom;
    return i;
  endfunction

  function automatic instr_t mk_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    instr_t i = base();
    i.aluop = 3'd2; i.regwrite = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_lw(logic [4:0] rd, logic [4:0] rs1);
    instr_t i = base();
    i.alusrc = 1'b1; i.regwrite = 1'b1; i.memread = 1'b1; i.lw = 1'b1;
    i.memtoreg = 2'd1; i.rd = rd; i.rs1 = rs1; i.rs2 = rd;
    return i;
  endfunction

  function automatic instr_t mk_sw(logic [4:0] rs1, logic [4:0] rs2);
    instr_t i = base();
    i.alusrc = 1'b1; i.memwrite = 1'b1; i.sw = 1'b1; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_lui(logic [4:0] rd);
    instr_t i = base();
    i.alusrc = 1'b1; i.regwrite = 1'b1; i.lui = 1'b1; i.rd = rd; i.rs1 = rd; i.rs2 = rd;
    return i;
  endfunction

  function automatic instr_t mk_jal(logic [4:0] rd);
    instr_t i = base();
    i.alusrc = 1'b1; i.regwrite = 1'b1; i.jal = 1'b1; i.memtoreg = 2'd2;
    i.pcsrc = 2'd1; i.rd = rd; i.rs1 = 5'd5; i.rs2 = 5'd5;
    return i;
  endfunction

  function automatic instr_t mk_rand();
    instr_t i;
    i = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    i.valid = ($urandom_range(0, 7) != 0);
    i.rs1 = 5'($urandom_range(0, 3));
    i.rs2 = 5'($urandom_range(0, 3));
    i.rd  = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // Does ID instruction i read the register a load in EX is about to write?
  function automatic bit reads_load_dest(instr_t i);
    bit r1, r2;
    if (!(i.valid && m_ex.valid && m_ex.memread) || m_ex.rd == 5'd0) return 0;
    r1 = !(i.lui || i.jal) && (i.rs1 == m_ex.rd);
    r2 = (!i.alusrc || i.sw || i.branch) && (i.rs2 == m_ex.rd);
    return r1 || r2;
  endfunction

  // One clock: drive ID, predict this cycle's stall and current EX, then step the model
  task automatic cyc(instr_t i, bit r = 1, bit h = 0, bit f = 0);
    bit haz;
    exp_t e;
    id_i = i; rst_n = r; hold = h; flush = f;
    haz = reads_load_dest(i);
    if (m_known) begin
      e.stall = haz && !(f || m_fpend) && !h;
      e.ex    = m_ex;
      e.cnt   = CNTW'(m_cnt);
      sb.push_back(e);
    end
    if (!r) begin
      m_ex = '0; m_cnt = 0; m_fpend = 0;
    end else if (h) begin
      m_fpend = m_fpend || f;
    end else if (f || m_fpend) begin
      m_ex = '0; m_fpend = 0;
    end else if (haz) begin
      m_ex = '0;
      if (m_cnt < CNTMAX) m_cnt++;
    end else begin
      m_ex = i;
    end
    m_known = 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the oldest prediction mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (stall_if !== e.stall) begin
          errors++;
          $display("FAIL stall_if t=%0t got %b exp %b", $time, stall_if, e.stall);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, e.cnt);
        end
        checks++;
        if (act !== e.ex) begin
          errors++;
          $display("FAIL ex_bundle t=%0t got %h exp %h", $time, act, e.ex);
        end
      end
    end
  end

  initial begin
    instr_t add6;
    int wait_cnt;
    id_i = '0; rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    add6 = mk_add(6, 5, 1);

    // Reset held for two edges with a valid ADD on ID, then released
    cyc(mk_add(3, 1, 2), 0);
    cyc(mk_add(3, 1, 2), 0);
    cyc(mk_add(3, 1, 2));
    cyc(mk_add(4, 1, 2));

    // Load-use: LW x5 then ADD x6,x5,x1 (re-presented while stalled)
    cyc(mk_lw(5, 1)); cyc(add6); cyc(add6); cyc(mk_add(7, 1, 2));

    // No false hazards: x0 destination, LUI and JAL ignore x5 fields
    cyc(mk_lw(0, 1)); cyc(mk_add(6, 0, 0));
    cyc(mk_lw(5, 1)); cyc(mk_lui(5));
    cyc(mk_lw(5, 1)); cyc(mk_jal(1));
    // SW reading x5 as store data does stall
    cyc(mk_lw(5, 1)); cyc(mk_sw(1, 5)); cyc(mk_sw(1, 5));

    // Flush beats hazard
    cyc(mk_lw(5, 1)); cyc(add6, 1, 0, 1); cyc(mk_add(7, 1, 2));

    // Hold for three cycles, flush pulsed mid-hold, applied once hold drops
    cyc(mk_add(9, 1, 2));
    cyc(mk_rand(), 1, 1, 0); cyc(mk_rand(), 1, 1, 1); cyc(mk_rand(), 1, 1, 0);
    cyc(mk_add(10, 1, 2)); cyc(mk_add(11, 1, 2)); cyc(mk_add(12, 1, 2));

    // Counter saturation from zero with 17 hazards
    cyc(mk_add(1, 1, 1), 0);
    for (int k = 0; k < 17; k++) begin
      cyc(mk_lw(5, 1)); cyc(add6);
    end
    cyc(mk_add(7, 1, 2));
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL cnt_saturate got %0d exp 15", stall_cnt);
    end

    // Random traffic with occasional hold, flush and reset
    for (int k = 0; k < 400; k++) begin
      cyc(mk_rand(), $urandom_range(0, 49) != 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 5) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
